// File: rtl/prv664_fdispatch_hazard.sv
// FP dispatch hazard stage: holds one decoded FP instruction, checks its registers
// against the FP scoreboard (with same-cycle commit wakeup) and issues it downstream.
module prv664_fdispatch_hazard #(
  parameter int    IDLEN = 8,
  parameter string RNM   = "ENABLE"
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       in_rs_used_i,
  input  logic [4:0]       in_rs1index_i,
  input  logic [4:0]       in_rs2index_i,
  input  logic [4:0]       in_rs3index_i,
  input  logic             in_rd_wren_i,
  input  logic [4:0]       in_rdindex_i,
  input  logic [IDLEN-1:0] in_itag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2:0]       out_rs_used_o,
  output logic [4:0]       out_rs1index_o,
  output logic [4:0]       out_rs2index_o,
  output logic [4:0]       out_rs3index_o,
  output logic             out_rd_wren_o,
  output logic [4:0]       out_rdindex_o,
  output logic [IDLEN-1:0] out_itag_o,
  input  logic [31:0]      busy_flag_i,
  input  logic [31:0][7:0] id_flag_i,
  input  logic             commit0_valid_i,
  input  logic             commit0_wren_i,
  input  logic [4:0]       commit0_rdindex_i,
  input  logic [7:0]       commit0_itag_i,
  output logic             sb_write_o,
  output logic [4:0]       sb_rdindex_o,
  output logic [IDLEN-1:0] sb_itag_o,
  output logic [15:0]      stall_cnt_o
);

  // With renaming a busy destination is harmless; without it WAW must stall too.
  localparam bit WAW_STALL = (RNM != "ENABLE");

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_READY} state_e;

  logic             hold_valid;
  logic [2:0]       hold_rs_used;
  logic [4:0]       hold_rs1, hold_rs2, hold_rs3, hold_rd;
  logic             hold_rd_wren;
  logic [IDLEN-1:0] hold_itag;

  logic [31:0] commit_clr;
  logic [31:0] eff_busy;
  logic [2:0]  src_busy;
  logic        rd_busy;
  logic        hazard;
  logic        fire;
  logic        accept;
  state_e      state;

  // A commit whose tag matches the register's pending tag frees it this cycle;
  // an older producer's commit (tag mismatch) does not.
  always_comb begin
    commit_clr = '0;
    if (commit0_valid_i && commit0_wren_i)
      commit_clr[commit0_rdindex_i] =
        (commit0_itag_i[IDLEN-1:0] == id_flag_i[commit0_rdindex_i][IDLEN-1:0]);
  end

  assign eff_busy    = busy_flag_i & ~commit_clr;
  assign src_busy[0] = hold_rs_used[0] & eff_busy[hold_rs1];
  assign src_busy[1] = hold_rs_used[1] & eff_busy[hold_rs2];
  assign src_busy[2] = hold_rs_used[2] & eff_busy[hold_rs3];
  assign rd_busy     = WAW_STALL & hold_rd_wren & eff_busy[hold_rd];
  assign hazard      = (|src_busy) | rd_busy;

  always_comb begin
    if (!hold_valid)  state = ST_EMPTY;
    else if (hazard)  state = ST_WAIT;
    else              state = ST_READY;
  end

  // Both sides use valid/ready: a transfer happens on a rising clk edge where
  // valid and ready are both high; flush_i blocks both sides for that cycle.
  assign out_valid_o = (state == ST_READY) & ~flush_i;
  assign fire        = out_valid_o & out_ready_i;
  assign in_ready_o  = ~flush_i & (~hold_valid | fire);
  assign accept      = in_valid_i & in_ready_o;

  assign out_rs_used_o  = hold_rs_used;
  assign out_rs1index_o = hold_rs1;
  assign out_rs2index_o = hold_rs2;
  assign out_rs3index_o = hold_rs3;
  assign out_rd_wren_o  = hold_rd_wren;
  assign out_rdindex_o  = hold_rd;
  assign out_itag_o     = hold_itag;

  // The scoreboard marks rd busy at the fire edge, so a dependent instruction
  // loaded at that same edge sees the busy bit one cycle later.
  assign sb_write_o   = fire & hold_rd_wren;
  assign sb_rdindex_o = hold_rd;
  assign sb_itag_o    = hold_itag;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      hold_valid   <= 1'b0;
      hold_rs_used <= '0;
      hold_rs1     <= '0;
      hold_rs2     <= '0;
      hold_rs3     <= '0;
      hold_rd_wren <= 1'b0;
      hold_rd      <= '0;
      hold_itag    <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (flush_i) begin
        hold_valid <= 1'b0;
      end else if (accept) begin
        hold_valid   <= 1'b1;
        hold_rs_used <= in_rs_used_i;
        hold_rs1     <= in_rs1index_i;
        hold_rs2     <= in_rs2index_i;
        hold_rs3     <= in_rs3index_i;
        hold_rd_wren <= in_rd_wren_i;
        hold_rd      <= in_rdindex_i;
        hold_itag    <= in_itag_i;
      end else if (fire) begin
        hold_valid <= 1'b0;
      end
      if ((state == ST_WAIT) && !flush_i && (stall_cnt_o != 16'hFFFF))
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_prv664_fdispatch_hazard.sv
// Directed bench for prv664_fdispatch_hazard: a renaming and a non-renaming
// instance share all inputs; hazard table plus multi-cycle sequences.
module tb_prv664_fdispatch_hazard;

  logic             clk = 1'b0;
  logic             arst_ni = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [2:0]       in_rs_used = '0;
  logic [4:0]       in_rs1 = '0, in_rs2 = '0, in_rs3 = '0, in_rd = '0;
  logic             in_rd_wren = 1'b0;
  logic [7:0]       in_itag = '0;
  logic             out_ready = 1'b0;
  logic [31:0]      busy = '0;
  logic [31:0][7:0] id_flag = '0;
  logic             c_valid = 1'b0, c_wren = 1'b0;
  logic [4:0]       c_rd = '0;
  logic [7:0]       c_itag = '0;

  logic        e_in_ready, e_out_valid, e_rd_wren, e_sb_write;
  logic [2:0]  e_rs_used;
  logic [4:0]  e_rs1, e_rs2, e_rs3, e_rd, e_sb_rd;
  logic [7:0]  e_itag, e_sb_itag;
  logic [15:0] e_stall;
  logic        d_in_ready, d_out_valid, d_rd_wren, d_sb_write;
  logic [2:0]  d_rs_used;
  logic [4:0]  d_rs1, d_rs2, d_rs3, d_rd, d_sb_rd;
  logic [7:0]  d_itag, d_sb_itag;
  logic [15:0] d_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prv664_fdispatch_hazard #(.IDLEN(8), .RNM("ENABLE")) u_en (
    .clk_i(clk), .arst_ni(arst_ni), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(e_in_ready), .in_rs_used_i(in_rs_used),
    .in_rs1index_i(in_rs1), .in_rs2index_i(in_rs2), .in_rs3index_i(in_rs3),
    .in_rd_wren_i(in_rd_wren), .in_rdindex_i(in_rd), .in_itag_i(in_itag),
    .out_valid_o(e_out_valid), .out_ready_i(out_ready), .out_rs_used_o(e_rs_used),
    .out_rs1index_o(e_rs1), .out_rs2index_o(e_rs2), .out_rs3index_o(e_rs3),
    .out_rd_wren_o(e_rd_wren), .out_rdindex_o(e_rd), .out_itag_o(e_itag),
    .busy_flag_i(busy), .id_flag_i(id_flag),
    .commit0_valid_i(c_valid), .commit0_wren_i(c_wren),
    .commit0_rdindex_i(c_rd), .commit0_itag_i(c_itag),
    .sb_write_o(e_sb_write), .sb_rdindex_o(e_sb_rd), .sb_itag_o(e_sb_itag),
    .stall_cnt_o(e_stall)
  );

  prv664_fdispatch_hazard #(.IDLEN(8), .RNM("DISABLE")) u_dis (
    .clk_i(clk), .arst_ni(arst_ni), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(d_in_ready), .in_rs_used_i(in_rs_used),
    .in_rs1index_i(in_rs1), .in_rs2index_i(in_rs2), .in_rs3index_i(in_rs3),
    .in_rd_wren_i(in_rd_wren), .in_rdindex_i(in_rd), .in_itag_i(in_itag),
    .out_valid_o(d_out_valid), .out_ready_i(out_ready), .out_rs_used_o(d_rs_used),
    .out_rs1index_o(d_rs1), .out_rs2index_o(d_rs2), .out_rs3index_o(d_rs3),
    .out_rd_wren_o(d_rd_wren), .out_rdindex_o(d_rd), .out_itag_o(d_itag),
    .busy_flag_i(busy), .id_flag_i(id_flag),
    .commit0_valid_i(c_valid), .commit0_wren_i(c_wren),
    .commit0_rdindex_i(c_rd), .commit0_itag_i(c_itag),
    .sb_write_o(d_sb_write), .sb_rdindex_o(d_sb_rd), .sb_itag_o(d_sb_itag),
    .stall_cnt_o(d_stall)
  );

  typedef struct {
    logic [2:0]  used;
    logic [4:0]  rs1, rs2, rs3;
    logic        wren;
    logic [4:0]  rd;
    logic [7:0]  itag;
    logic [31:0] busy;
    logic [7:0]  sb_tag;
    logic        cv, cw;
    logic [4:0]  crd;
    logic [7:0]  ctag;
    logic        exp_en, exp_dis;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_rs_used = '0; in_rs1 = '0; in_rs2 = '0;
    in_rs3 = '0; in_rd_wren = 1'b0; in_rd = '0; in_itag = '0; out_ready = 1'b0;
    busy = '0; id_flag = '0; c_valid = 1'b0; c_wren = 1'b0; c_rd = '0; c_itag = '0;
  endtask

  task automatic do_reset();
    arst_ni = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    arst_ni = 1'b1;
  endtask

  task automatic set_instr(input logic [2:0] used, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rs3, input logic wren, input logic [4:0] rd,
                           input logic [7:0] itag);
    in_rs_used = used; in_rs1 = rs1; in_rs2 = rs2; in_rs3 = rs3;
    in_rd_wren = wren; in_rd = rd; in_itag = itag;
  endtask

  task automatic set_all_tags(input logic [7:0] t);
    for (int r = 0; r < 32; r++) id_flag[r] = t;
  endtask

  initial begin
    //        used    rs1   rs2   rs3    wren  rd    itag   busy          sbtag  cv    cw    crd   ctag   en    dis
    vecs[0]  = '{3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 8'h01, 32'h20,       8'h12, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 8'h02, 32'h20,       8'h12, 1'b1, 1'b1, 5'd5, 8'h12, 1'b1, 1'b1};
    vecs[2]  = '{3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 8'h03, 32'h20,       8'h12, 1'b1, 1'b1, 5'd5, 8'h11, 1'b0, 1'b0};
    vecs[3]  = '{3'b000, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 8'h04, 32'h20,       8'h12, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1};
    vecs[4]  = '{3'b010, 5'd1, 5'd9, 5'd0, 1'b0, 5'd0, 8'h05, 32'h200,      8'h33, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{3'b100, 5'd1, 5'd2, 5'd31,1'b0, 5'd0, 8'h06, 32'h8000_0000,8'h33, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 8'h07, 32'h8,        8'h44, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 8'h08, 32'h8,        8'h44, 1'b1, 1'b1, 5'd3, 8'h44, 1'b1, 1'b1};
    vecs[8]  = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 8'h09, 32'h8,        8'h44, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 8'h10, 32'h20,       8'h12, 1'b1, 1'b0, 5'd5, 8'h12, 1'b0, 1'b0};
    vecs[10] = '{3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 8'h11, 32'h20,       8'h12, 1'b0, 1'b1, 5'd5, 8'h12, 1'b0, 1'b0};
    vecs[11] = '{3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 8'h12, 32'h20,       8'h12, 1'b1, 1'b1, 5'd6, 8'h12, 1'b0, 1'b0};
    vecs[12] = '{3'b111, 5'd1, 5'd2, 5'd4, 1'b0, 5'd0, 8'h13, 32'h4,        8'h55, 1'b1, 1'b1, 5'd2, 8'h55, 1'b1, 1'b1};
    vecs[13] = '{3'b111, 5'd1, 5'd2, 5'd4, 1'b0, 5'd0, 8'h14, 32'h14,       8'h55, 1'b1, 1'b1, 5'd2, 8'h55, 1'b0, 1'b0};
    vecs[14] = '{3'b011, 5'd6, 5'd6, 5'd0, 1'b1, 5'd6, 8'h15, 32'h40,       8'h66, 1'b1, 1'b1, 5'd6, 8'h66, 1'b1, 1'b1};

    // Reset values
    do_reset();
    #1;
    check("rst_out_valid", e_out_valid, 0);
    check("rst_sb_write", e_sb_write, 0);
    check("rst_stall", e_stall, 0);
    check("rst_in_ready", e_in_ready, 1);
    check("rst_out_itag", e_itag, 0);

    // Hazard table: flush, load with scoreboard clear, then apply vector scoreboard state
    for (int v = 0; v < 15; v++) begin
      @(negedge clk);
      idle_inputs();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      set_instr(vecs[v].used, vecs[v].rs1, vecs[v].rs2, vecs[v].rs3,
                vecs[v].wren, vecs[v].rd, vecs[v].itag);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      busy = vecs[v].busy;
      set_all_tags(vecs[v].sb_tag);
      c_valid = vecs[v].cv; c_wren = vecs[v].cw; c_rd = vecs[v].crd; c_itag = vecs[v].ctag;
      #1;
      check($sformatf("vec%0d_valid_ren", v), e_out_valid, vecs[v].exp_en);
      check($sformatf("vec%0d_valid_noren", v), d_out_valid, vecs[v].exp_dis);
      check($sformatf("vec%0d_itag", v), e_itag, vecs[v].itag);
    end

    // Independent stream: one issue per cycle, no bubbles
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        set_instr(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'(10 + i), 8'(8'h40 + i));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i >= 1) begin
        check($sformatf("stream%0d_valid", i), e_out_valid, 1);
        check($sformatf("stream%0d_sb_write", i), e_sb_write, 1);
        check($sformatf("stream%0d_sb_itag", i), e_sb_itag, 8'h40 + i - 1);
        check($sformatf("stream%0d_sb_rd", i), e_sb_rd, 10 + i - 1);
        check($sformatf("stream%0d_in_ready", i), e_in_ready, 1);
      end
    end
    @(negedge clk);
    #1;
    check("stream_drain_valid", e_out_valid, 0);
    check("stream_drain_sb_write", e_sb_write, 0);
    check("stream_stall", e_stall, 0);

    // RAW stall released by a same-cycle matching commit
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    set_instr(3'b001, 5'd5, 5'd0, 5'd0, 1'b1, 5'd8, 8'h50);
    in_valid = 1'b1;
    busy = 32'h20;
    id_flag[5] = 8'h12;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("raw_stall%0d_valid", c), e_out_valid, 0);
      @(negedge clk);
    end
    check("raw_stall_cnt", e_stall, 3);
    c_valid = 1'b1; c_wren = 1'b1; c_rd = 5'd5; c_itag = 8'h12;
    #1;
    check("raw_bypass_valid", e_out_valid, 1);
    check("raw_bypass_sb_write", e_sb_write, 1);
    check("raw_bypass_sb_itag", e_sb_itag, 8'h50);
    @(negedge clk);
    c_valid = 1'b0; busy = '0;
    #1;
    check("raw_after_valid", e_out_valid, 0);
    check("raw_after_stall", e_stall, 3);

    // Stale commit (older producer tag) does not release
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    set_instr(3'b010, 5'd0, 5'd7, 5'd0, 1'b0, 5'd0, 8'h60);
    in_valid = 1'b1;
    busy = 32'h80;
    id_flag[7] = 8'h20;
    @(negedge clk);
    in_valid = 1'b0;
    c_valid = 1'b1; c_wren = 1'b1; c_rd = 5'd7; c_itag = 8'h1F;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("stale%0d_valid", c), e_out_valid, 0);
      @(negedge clk);
    end
    c_valid = 1'b0; busy = '0;
    #1;
    check("stale_release_valid", e_out_valid, 1);

    // WAW: renaming instance issues, non-renaming waits for rd to clear
    do_reset();
    @(negedge clk);
    set_instr(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 8'h70);
    in_valid = 1'b1;
    busy = 32'h8;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("waw%0d_ren_valid", c), e_out_valid, 1);
      check($sformatf("waw%0d_noren_valid", c), d_out_valid, 0);
      @(negedge clk);
    end
    busy = '0;
    #1;
    check("waw_noren_release", d_out_valid, 1);
    check("waw_noren_no_write", d_sb_write, 0);
    out_ready = 1'b1;
    #1;
    check("waw_noren_sb_write", d_sb_write, 1);
    check("waw_noren_sb_rd", d_sb_rd, 3);

    // Backpressure hold, then flush wins over fire and drops the input
    do_reset();
    @(negedge clk);
    set_instr(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 8'h81);
    in_valid = 1'b1;
    @(negedge clk);
    set_instr(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd12, 8'h99);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d_valid", c), e_out_valid, 1);
      check($sformatf("bp%0d_sb_write", c), e_sb_write, 0);
      check($sformatf("bp%0d_itag", c), e_itag, 8'h81);
      check($sformatf("bp%0d_rd", c), e_rd, 9);
      check($sformatf("bp%0d_in_ready", c), e_in_ready, 0);
      @(negedge clk);
    end
    flush = 1'b1;
    out_ready = 1'b1;
    set_instr(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd13, 8'h82);
    #1;
    check("flush_in_ready", e_in_ready, 0);
    check("flush_out_valid", e_out_valid, 0);
    check("flush_sb_write", e_sb_write, 0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_flush_in_ready", e_in_ready, 1);
    check("post_flush_valid", e_out_valid, 0);

    // Stall counter saturation, then asynchronous reset mid-cycle
    do_reset();
    @(negedge clk);
    set_instr(3'b001, 5'd5, 5'd0, 5'd0, 1'b1, 5'd2, 8'h90);
    in_valid = 1'b1;
    busy = 32'h20;
    id_flag[5] = 8'h77;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    check("sat_stall", e_stall, 16'hFFFF);
    check("sat_valid", e_out_valid, 0);
    check("sat_itag", e_itag, 8'h90);
    #2;
    arst_ni = 1'b0;
    #1;
    check("arst_stall", e_stall, 0);
    check("arst_valid", e_out_valid, 0);
    check("arst_sb_write", e_sb_write, 0);
    check("arst_itag", e_itag, 0);
    check("arst_in_ready", e_in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
